// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and the sequence detector bench that consumes its stream.
package bit_serializer_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: takes WIDTH-bit words over valid/ready and shifts them out one
// bit per enabled clock, chaining back-to-back words with no gap bit.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned       CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]   LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             last_bit;
  logic             accept;

  always_comb begin
    last_bit   = (state_q == StShift) && (cnt_q == LastCnt);
    load_ready = reset & bit_en & ((state_q == StIdle) | last_bit);
    accept     = load_valid & load_ready;
    word_done  = last_bit;
    busy       = (state_q == StShift);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (accept) begin
      // Covers both a load from idle and the gapless reload on the last bit.
      shift_d = load_data;
      cnt_d   = '0;
      state_d = StShift;
    end else if (bit_en && (state_q == StShift)) begin
      if (last_bit) begin
        state_d = StIdle;
      end else begin
        shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  // Output flops are fed from next-state so dout always tracks the bit at the shift register head.
  always_comb begin
    dout_d       = IDLE_BIT;
    dout_valid_d = 1'b0;
    if (state_d == StShift) begin
      dout_d       = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= IDLE_BIT;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB- and LSB-first instances share stimulus and are checked each
// cycle against a queue-of-pending-bits model, plus directed literal checks.
module tb_bit_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       bit_en = 1'b1;
  logic [7:0] load_data = '0;
  logic       load_valid = 1'b0;

  logic m_ready, m_dout, m_dv, m_wd, m_busy;
  logic l_ready, l_dout, l_dv, l_wd, l_busy;

  int checks = 0;
  int failures = 0;

  bit qm[$];
  bit ql[$];
  bit acc_evt = 1'b0;
  bit started = 1'b0;

  bit cap_m[$];
  bit cap_l[$];
  bit cap_wd[$];
  bit win = 1'b0;
  int rdy_cnt = 0;

  always #5 clock = ~clock;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clock(clock), .reset(reset), .bit_en(bit_en), .load_data(load_data),
    .load_valid(load_valid), .load_ready(m_ready), .dout(m_dout), .dout_valid(m_dv),
    .word_done(m_wd), .busy(m_busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .bit_en(bit_en), .load_data(load_data),
    .load_valid(load_valid), .load_ready(l_ready), .dout(l_dout), .dout_valid(l_dv),
    .word_done(l_wd), .busy(l_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return reset && bit_en && (qm.size() <= 1);
  endfunction

  // {load_ready, busy, dout_valid, word_done, dout}
  function automatic logic [4:0] exp_vec(input int sz, input bit head, input bit rdy);
    logic [4:0] v;
    v[4] = rdy;
    v[3] = (sz > 0);
    v[2] = (sz > 0);
    v[1] = (sz == 1);
    v[0] = (sz > 0) ? head : 1'b0;
    return v;
  endfunction

  // Model: a queue of the bits still to appear; its head is the bit currently on dout.
  always @(posedge clock) begin
    bit rdy;
    rdy     = model_ready();
    acc_evt = 1'b0;
    started = 1'b1;
    if (!reset) begin
      qm.delete();
      ql.delete();
    end else if (bit_en) begin
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (load_valid && rdy) begin
        for (int i = 7; i >= 0; i--) qm.push_back(load_data[i]);
        for (int i = 0; i < 8; i++) ql.push_back(load_data[i]);
        acc_evt = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      bit rdy;
      rdy = model_ready();
      chk("msb_outputs", {27'd0, m_ready, m_busy, m_dv, m_wd, m_dout},
          {27'd0, exp_vec(qm.size(), (qm.size() > 0) ? qm[0] : 1'b0, rdy)});
      chk("lsb_outputs", {27'd0, l_ready, l_busy, l_dv, l_wd, l_dout},
          {27'd0, exp_vec(ql.size(), (ql.size() > 0) ? ql[0] : 1'b0, rdy)});
      if (m_dv === 1'b1) begin
        cap_m.push_back(m_dout);
        cap_wd.push_back(m_wd);
      end
      if (l_dv === 1'b1) cap_l.push_back(l_dout);
      if (win && load_valid && m_ready === 1'b1) rdy_cnt++;
    end
  end

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_caps();
    cap_m.delete();
    cap_l.delete();
    cap_wd.delete();
  endtask

  task automatic wait_acc();
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 50) begin
      step();
      got = acc_evt;
      n++;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [7:0] d);
    load_data  = d;
    load_valid = 1'b1;
    wait_acc();
    load_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Test 1: reset then 8'hB5 MSB first
    reset = 1'b0;
    repeat (3) step();
    chk("reset_dout_valid", {31'd0, m_dv}, 32'd0);
    chk("reset_busy", {31'd0, m_busy}, 32'd0);
    reset = 1'b1;
    step();
    clear_caps();
    send(8'hB5);
    repeat (10) step();
    chk("t1_len", cap_m.size(), 32'd8);
    chk("t1_stream", pack(cap_m), 32'h0000_00B5);
    chk("t1_word_done", pack(cap_wd), 32'h0000_0001);
    chk("t1_lsb_stream", pack(cap_l), 32'h0000_00AD);
    chk("t1_idle_dout", {30'd0, m_dv, m_dout}, 32'd0);

    // Test 2: back-to-back A5, 0F with valid held
    clear_caps();
    rdy_cnt    = 0;
    win        = 1'b1;
    load_data  = 8'hA5;
    load_valid = 1'b1;
    wait_acc();
    load_data = 8'h0F;
    wait_acc();
    load_valid = 1'b0;
    win        = 1'b0;
    repeat (18) step();
    chk("t2_len", cap_m.size(), 32'd16);
    chk("t2_stream", pack(cap_m), 32'h0000_A50F);
    chk("t2_ready_cycles", rdy_cnt, 32'd2);

    // Test 3: 8'h01 on the LSB-first instance
    clear_caps();
    send(8'h01);
    repeat (10) step();
    chk("t3_lsb_stream", pack(cap_l), 32'h0000_0080);
    chk("t3_msb_stream", pack(cap_m), 32'h0000_0001);

    // Test 4: bit_en toggling during 8'hC3
    clear_caps();
    send(8'hC3);
    for (int i = 0; i < 16; i++) begin
      bit_en = (i % 2 == 1);
      step();
    end
    bit_en = 1'b1;
    repeat (4) step();
    chk("t4_len", cap_m.size(), 32'd16);
    chk("t4_stream", pack(cap_m), 32'h0000_F00F);

    // Test 5: reset mid-word
    clear_caps();
    send(8'hFF);
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("t5_reset_outs", {29'd0, m_dout, m_dv, m_busy}, 32'd0);
    reset = 1'b1;
    step();
    clear_caps();
    send(8'h81);
    repeat (10) step();
    chk("t5_len", cap_m.size(), 32'd8);
    chk("t5_stream", pack(cap_m), 32'h0000_0081);

    // Test 6: valid raised mid-word is held off until the last bit
    clear_caps();
    send(8'h3C);
    repeat (2) step();
    load_data  = 8'h5A;
    load_valid = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clock);
      if (m_ready === 1'b1) break;
      n++;
    end
    chk("t6_wait_cycles", n, 32'd5);
    wait_acc();
    load_valid = 1'b0;
    repeat (10) step();
    chk("t6_len", cap_m.size(), 32'd16);
    chk("t6_stream", pack(cap_m), 32'h0000_3C5A);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 99) != 0);
      bit_en = ($urandom_range(0, 3) != 0);
      if (!load_valid && $urandom_range(0, 2) == 0) begin
        load_valid = 1'b1;
        load_data  = 8'($urandom);
      end
      step();
      if (acc_evt) load_valid = 1'b0;
    end
    reset      = 1'b1;
    bit_en     = 1'b1;
    load_valid = 1'b0;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
